// File: rtl/resampler_pkg.sv
// Shared types and register map for the multi-channel resampler.
package resampler_pkg;

    typedef enum logic {
        MODE_PEAK   = 1'b0,
        MODE_SAMPLE = 1'b1
    } mode_e;

    localparam logic [7:0] OFF_DIV0   = 8'd0;
    localparam logic [7:0] OFF_DIV1   = 8'd1;
    localparam logic [7:0] OFF_DIV2   = 8'd2;
    localparam logic [7:0] OFF_CTRL   = 8'd3;
    localparam logic [7:0] OFF_FREQ0  = 8'd0;
    localparam logic [7:0] OFF_FREQ1  = 8'd1;
    localparam logic [7:0] OFF_FREQ2  = 8'd2;
    localparam logic [7:0] OFF_FREQ3  = 8'd3;
    localparam logic [7:0] OFF_STATUS = 8'd4;

    localparam logic [23:0] RESET_DIVIDER = 24'd1;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/resampler_chan.sv
// One channel: running min/max over the current frame and the registered frame result.
module resampler_chan #(
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              frame_start,
    input  logic              advance,
    input  logic              emit,
    input  logic              sample_mode,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min
);
    import resampler_pkg::*;

    logic [DATA_W-1:0] acc_max_r;
    logic [DATA_W-1:0] acc_min_r;
    logic [DATA_W-1:0] cur_max_s;
    logic [DATA_W-1:0] cur_min_s;

    // Frame extremes including this cycle's sample; first sample of a frame stands alone.
    always_comb begin
        cur_max_s = sample;
        cur_min_s = sample;
        if (frame_start) begin
            cur_max_s = sample;
            cur_min_s = sample;
        end else begin
            cur_max_s = (sample > acc_max_r) ? sample : acc_max_r;
            cur_min_s = (sample < acc_min_r) ? sample : acc_min_r;
        end
    end

    // Running accumulators, frozen while the resampler is disabled.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc_max_r <= {DATA_W{1'b0}};
            acc_min_r <= {DATA_W{1'b0}};
        end else if (advance) begin
            acc_max_r <= cur_max_s;
            acc_min_r <= cur_min_s;
        end
    end

    // Frame result capture on the terminal cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            out_max <= {DATA_W{1'b0}};
            out_min <= {DATA_W{1'b0}};
        end else if (emit) begin
            out_max <= sample_mode ? sample : cur_max_s;
            out_min <= sample_mode ? sample : cur_min_s;
        end
    end

endmodule

// File: rtl/resampler_mc.sv
// Multi-channel decimating peak/sample resampler with a gated zero-crossing
// frequency counter on channel 0, configured over an 8-bit port bus.
module resampler_mc #(
    parameter int DATA_W     = 8,
    parameter int CHANNELS   = 2,
    parameter int DIV_W      = 24,
    parameter int BASE       = 0,
    parameter int GATE_TICKS = 120000000,
    parameter int HYST       = 2,
    parameter int CNT_W      = 28
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic [7:0]                   port_id,
    input  logic [7:0]                   out_port,
    input  logic                         write_strobe,
    output logic [7:0]                   in_port,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    output logic [CHANNELS*DATA_W-1:0]   data_out_max,
    output logic [CHANNELS*DATA_W-1:0]   data_out_min,
    output logic                         out_valid,
    output logic [CNT_W-1:0]             freq_count
);
    import resampler_pkg::*;

    localparam logic [7:0]        BASE_ADDR = 8'(BASE);
    localparam int                GATE_W    = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam int                XW        = DATA_W + 1;
    localparam logic [XW-1:0]     HYST_X    = XW'(HYST);
    localparam logic [XW-1:0]     FULL_X    = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W-1:0] MID_RESET = {1'b1, {(DATA_W-1){1'b0}}};

    logic [7:0]        offset_s;
    logic              wr_ctrl_s;
    logic [23:0]       div_stage_r;
    logic [DIV_W-1:0]  divider_r;
    mode_e             mode_r;
    logic              enable_r;
    logic [DIV_W-1:0]  counter_r;
    logic              terminal_s;
    logic              frame_start_s;
    logic              emit_s;
    logic              out_valid_r;

    assign offset_s      = port_id - BASE_ADDR;
    assign wr_ctrl_s     = write_strobe && (offset_s == OFF_CTRL);
    assign terminal_s    = (counter_r == divider_r);
    assign frame_start_s = (counter_r == {DIV_W{1'b0}});
    assign emit_s        = enable_r && terminal_s;
    assign out_valid     = out_valid_r;

    // Divider staging bytes; nothing takes effect until the control write.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_stage_r <= RESET_DIVIDER;
        end else if (write_strobe) begin
            if (offset_s == OFF_DIV0) div_stage_r[7:0]   <= out_port;
            if (offset_s == OFF_DIV1) div_stage_r[15:8]  <= out_port;
            if (offset_s == OFF_DIV2) div_stage_r[23:16] <= out_port;
        end
    end

    // Control register and divider commit.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            divider_r <= DIV_W'(RESET_DIVIDER);
            mode_r    <= MODE_PEAK;
            enable_r  <= 1'b1;
        end else if (wr_ctrl_s) begin
            divider_r <= DIV_W'(div_stage_r);
            mode_r    <= mode_e'(out_port[0]);
            enable_r  <= out_port[1];
        end
    end

    // Frame counter: a commit aborts the running frame but the terminal pulse of this cycle survives.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            counter_r   <= {DIV_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= emit_s;
            if (wr_ctrl_s || emit_s) begin
                counter_r <= {DIV_W{1'b0}};
            end else if (enable_r) begin
                counter_r <= counter_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        resampler_chan #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .sample      (data_in[c*DATA_W +: DATA_W]),
            .frame_start (frame_start_s),
            .advance     (enable_r),
            .emit        (emit_s),
            .sample_mode (mode_r == MODE_SAMPLE),
            .out_max     (data_out_max[c*DATA_W +: DATA_W]),
            .out_min     (data_out_min[c*DATA_W +: DATA_W])
        );
    end

    logic [DATA_W-1:0] ch0_s;
    logic [GATE_W-1:0] gate_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic [CNT_W-1:0]  freq_count_r;
    logic [DATA_W-1:0] mid_r;
    logic [DATA_W-1:0] gmax_r;
    logic [DATA_W-1:0] gmin_r;
    logic              armed_r;
    logic [XW-1:0]     mid_x_s;
    logic [XW-1:0]     lo_s;
    logic [XW-1:0]     hi_s;
    logic [XW-1:0]     mid_sum_s;
    logic              cross_s;
    logic              below_s;
    logic              gate_end_s;

    assign ch0_s      = data_in[DATA_W-1:0];
    assign mid_x_s    = {1'b0, mid_r};
    assign lo_s       = (mid_x_s >= HYST_X) ? (mid_x_s - HYST_X) : {XW{1'b0}};
    assign hi_s       = ((mid_x_s + HYST_X) > FULL_X) ? FULL_X : (mid_x_s + HYST_X);
    assign below_s    = ({1'b0, ch0_s} < lo_s);
    assign cross_s    = armed_r && ({1'b0, ch0_s} >= hi_s);
    assign gate_end_s = (gate_r == GATE_LAST);
    assign mid_sum_s  = {1'b0, gmax_r} + {1'b0, gmin_r};
    assign count_next_s = (cross_s && (count_r != CNT_MAX)) ? (count_r + {{(CNT_W-1){1'b0}}, 1'b1}) : count_r;
    assign freq_count = freq_count_r;

    // Hysteresis arm/fire, gate timing and adaptive zero line.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            gate_r       <= {GATE_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            freq_count_r <= {CNT_W{1'b0}};
            mid_r        <= MID_RESET;
            gmax_r       <= {DATA_W{1'b0}};
            gmin_r       <= {DATA_W{1'b0}};
            armed_r      <= 1'b0;
        end else begin
            if (cross_s) begin
                armed_r <= 1'b0;
            end else if (below_s) begin
                armed_r <= 1'b1;
            end
            if (gate_end_s) begin
                gate_r       <= {GATE_W{1'b0}};
                freq_count_r <= count_next_s;
                count_r      <= {CNT_W{1'b0}};
                mid_r        <= mid_sum_s[DATA_W:1];
                gmax_r       <= ch0_s;
                gmin_r       <= ch0_s;
            end else begin
                gate_r  <= gate_r + {{(GATE_W-1){1'b0}}, 1'b1};
                count_r <= count_next_s;
                gmax_r  <= (ch0_s > gmax_r) ? ch0_s : gmax_r;
                gmin_r  <= (ch0_s < gmin_r) ? ch0_s : gmin_r;
            end
        end
    end

    logic [31:0] freq_word_s;
    assign freq_word_s = 32'(freq_count_r);

    // Read-back mux; unmapped addresses read as zero.
    always_comb begin
        in_port = 8'h00;
        case (offset_s)
            OFF_FREQ0, OFF_FREQ1, OFF_FREQ2, OFF_FREQ3: in_port = byte_sel(freq_word_s, offset_s[1:0]);
            OFF_STATUS: in_port = {6'b000000, enable_r, (mode_r == MODE_SAMPLE)};
            default:    in_port = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_resampler_mc.sv
// Randomised scoreboard bench for resampler_mc with a frame/gate-level reference model.
module tb_resampler_mc;
    localparam int DATA_W = 8;
    localparam int GATE   = 1000;
    localparam int HYST   = 2;
    localparam int CNT_W  = 28;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       port_id = 8'd0;
    logic [7:0]       out_port = 8'd0;
    logic             write_strobe = 1'b0;
    logic [7:0]       in_port;
    logic [15:0]      data_in = 16'd0;
    logic [15:0]      data_out_max;
    logic [15:0]      data_out_min;
    logic             out_valid;
    logic [CNT_W-1:0] freq_count;

    always #5 clk_in = ~clk_in;

    resampler_mc #(
        .DATA_W(DATA_W), .CHANNELS(2), .DIV_W(24), .BASE(0),
        .GATE_TICKS(GATE), .HYST(HYST), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .in_port(in_port), .data_in(data_in),
        .data_out_max(data_out_max), .data_out_min(data_out_min),
        .out_valid(out_valid), .freq_count(freq_count)
    );

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;

    typedef struct {
        int          stamp;
        logic [15:0] mx;
        logic [15:0] mn;
    } exp_t;
    exp_t sb_q[$];

    // reference model state
    int         div_m = 1;
    logic [23:0] stage_m = 24'd1;
    logic       mode_m = 1'b0;
    logic       en_m = 1'b1;
    logic [7:0] fr0[$];
    logic [7:0] fr1[$];
    int         gate_m = 0;
    logic [7:0] gs_q[$];
    logic [7:0] gm_q[$];
    int         mid_m = 128;
    logic       armed_m = 1'b0;
    int         freq_m = 0;

    always @(posedge clk_in) if (rst_n) edges = edges + 1;

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void frame_result(input logic [7:0] q[$], input logic smode,
                                         output logic [7:0] mx, output logic [7:0] mn);
        mx = q[0];
        mn = q[0];
        foreach (q[i]) begin
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
        end
        if (smode) begin
            mx = q[q.size()-1];
            mn = q[q.size()-1];
        end
    endfunction

    task automatic model_edge(input logic [7:0] d0, input logic [7:0] d1, input logic wr,
                              input logic [7:0] addr, input logic [7:0] wdata);
        logic [7:0] mx0, mn0, mx1, mn1;
        exp_t e;
        int lo, hi, cnt, gmx, gmn;
        if (en_m) begin
            fr0.push_back(d0);
            fr1.push_back(d1);
            if (fr0.size() == div_m + 1) begin
                frame_result(fr0, mode_m, mx0, mn0);
                frame_result(fr1, mode_m, mx1, mn1);
                e.stamp = edges + 1;
                e.mx = {mx1, mx0};
                e.mn = {mn1, mn0};
                sb_q.push_back(e);
                fr0.delete();
                fr1.delete();
            end
        end
        if (wr) begin
            if (addr == 8'd0) stage_m[7:0] = wdata;
            if (addr == 8'd1) stage_m[15:8] = wdata;
            if (addr == 8'd2) stage_m[23:16] = wdata;
            if (addr == 8'd3) begin
                div_m = int'(stage_m);
                mode_m = wdata[0];
                en_m = wdata[1];
                fr0.delete();
                fr1.delete();
            end
        end
        gs_q.push_back(d0);
        if (gate_m == GATE - 1) begin
            lo = (mid_m >= HYST) ? mid_m - HYST : 0;
            hi = (mid_m + HYST > 255) ? 255 : mid_m + HYST;
            cnt = 0;
            foreach (gs_q[i]) begin
                if (armed_m && gs_q[i] >= hi) begin
                    cnt++;
                    armed_m = 1'b0;
                end else if (gs_q[i] < lo) begin
                    armed_m = 1'b1;
                end
            end
            freq_m = cnt;
            gmx = 0;
            gmn = 255;
            foreach (gm_q[i]) begin
                if (gm_q[i] > gmx) gmx = gm_q[i];
                if (gm_q[i] < gmn) gmn = gm_q[i];
            end
            mid_m = (gmx + gmn) / 2;
            gm_q.delete();
            gm_q.push_back(d0);
            gs_q.delete();
            gate_m = 0;
        end else begin
            gm_q.push_back(d0);
            gate_m++;
        end
    endtask

    task automatic step(input logic [7:0] d0, input logic [7:0] d1, input logic wr,
                        input logic [7:0] addr, input logic [7:0] wdata);
        @(negedge clk_in);
        data_in = {d1, d0};
        write_strobe = wr;
        port_id = addr;
        out_port = wdata;
        model_edge(d0, d1, wr, addr, wdata);
    endtask

    task automatic wreg(input logic [7:0] addr, input logic [7:0] wdata);
        step(rnd8(), rnd8(), 1'b1, addr, wdata);
    endtask

    task automatic check_read(input string name, input logic [7:0] addr, input logic [7:0] exp);
        step(rnd8(), rnd8(), 1'b0, addr, 8'd0);
        #1;
        check(name, 32'(in_port), 32'(exp));
    endtask

    // Monitor: every out_valid must match the oldest predicted frame, at the predicted edge.
    always @(posedge clk_in) begin
        #1;
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].stamp < edges) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_pulse: got no out_valid at edge %0d expected pulse", sb_q[0].stamp);
                void'(sb_q.pop_front());
            end
            if (out_valid) begin
                vectors++;
                if (sb_q.size() == 0 || sb_q[0].stamp != edges) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: got out_valid at edge %0d expected none", edges);
                end else begin
                    if (data_out_max !== sb_q[0].mx || data_out_min !== sb_q[0].mn) begin
                        miscompares++;
                        $display("FAIL frame@%0d: got max %h min %h expected max %h min %h",
                                 edges, data_out_max, data_out_min, sb_q[0].mx, sb_q[0].mn);
                    end
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    logic [7:0]  ramp [4];
    logic [15:0] snap_max, snap_min;
    logic [7:0]  rdiv;

    initial begin
        ramp = '{8'd10, 8'd50, 8'd20, 8'd5};
        gm_q.push_back(8'd0);
        repeat (3) @(negedge clk_in);
        port_id = 8'd4;
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_max", 32'(data_out_max), 32'd0);
        check("reset_min", 32'(data_out_min), 32'd0);
        check("reset_freq", 32'(freq_count), 32'd0);
        check("reset_status", 32'(in_port), 32'h02);
        @(posedge clk_in);
        #2 rst_n = 1'b1;

        // peak mode, divider 3, ramp on ch0
        wreg(8'd0, 8'd3); wreg(8'd1, 8'd0); wreg(8'd2, 8'd0); wreg(8'd3, 8'h02);
        for (int i = 0; i < 40; i++) step(ramp[i % 4], rnd8(), 1'b0, 8'h10, 8'd0);
        check("peak_ramp_max0", 32'(data_out_max[7:0]), 32'd50);
        check("peak_ramp_min0", 32'(data_out_min[7:0]), 32'd5);

        // sample mode, divider 0, counting ch1
        wreg(8'd0, 8'd0); wreg(8'd3, 8'h03);
        for (int i = 0; i < 20; i++) step(rnd8(), 8'(i), 1'b0, 8'h10, 8'd0);

        // divider 9 rewritten to 1 at counter 4
        wreg(8'd0, 8'd9); wreg(8'd3, 8'h02);
        wreg(8'd0, 8'd1);
        repeat (3) step(rnd8(), rnd8(), 1'b0, 8'h10, 8'd0);
        wreg(8'd3, 8'h02);
        for (int i = 0; i < 20; i++) step(rnd8(), rnd8(), 1'b0, 8'h10, 8'd0);

        // random dividers and modes, with stray writes
        for (int r = 0; r < 4; r++) begin
            rdiv = 8'($urandom_range(0, 6));
            wreg(8'd0, rdiv);
            wreg(8'd3, {6'd0, 1'b1, 1'($urandom_range(0, 1))});
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 15) == 0) wreg(8'd7, rnd8());
                else step(rnd8(), rnd8(), 1'b0, 8'h10, 8'd0);
            end
        end

        // disabled: no pulses, outputs frozen
        wreg(8'd3, 8'h00);
        step(rnd8(), rnd8(), 1'b0, 8'h10, 8'd0);
        snap_max = data_out_max;
        snap_min = data_out_min;
        repeat (50) step(rnd8(), rnd8(), 1'b0, 8'h10, 8'd0);
        check("frozen_max", 32'(data_out_max), 32'(snap_max));
        check("frozen_min", 32'(data_out_min), 32'(snap_min));
        check_read("status_disabled", 8'd4, 8'h00);
        check_read("unmapped_read", 8'd9, 8'h00);

        // frequency counter: align to a gate, then square wave for one full gate
        while (gate_m != 0) step(rnd8(), rnd8(), 1'b0, 8'h10, 8'd0);
        for (int i = 0; i < GATE; i++) step(((i % 10) < 5) ? 8'd0 : 8'd255, rnd8(), 1'b0, 8'h10, 8'd0);
        @(posedge clk_in);
        #2;
        check("freq_square_model", 32'(freq_count), 32'(freq_m));
        check("freq_square_100", 32'(freq_count), 32'd100);

        // noise around the zero line for one gate
        step(8'($urandom_range(127, 129)), rnd8(), 1'b0, 8'd0, 8'd0);
        #1;
        check("read_freq0", 32'(in_port), 32'h64);
        for (int i = 1; i < GATE; i++) step(8'($urandom_range(127, 129)), rnd8(), 1'b0, 8'h10, 8'd0);
        @(posedge clk_in);
        #2;
        check("freq_noise_model", 32'(freq_count), 32'(freq_m));
        check("freq_noise_zero", 32'(freq_count), 32'd0);

        repeat (5) @(negedge clk_in);
        check("pending_pulses", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
